// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// and the lane/extension helpers used by data_mem_ctrl.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate store data so any enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [15:0] half;
    sh   = word >> {lane, 3'b000};
    half = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   load_extend = {24'h0, sh[7:0]};
      F3_H:    load_extend = {{16{half[15]}}, half};
      F3_HU:   load_extend = {16'h0, half};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic bad_size;
    logic misaligned;
    if (is_store) bad_size = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else          bad_size = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    case (f3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    access_fault = bad_size | misaligned;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port that only updates when a read is issued.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder: holds the core with stall for LATENCY cycles, then
// presents extended load data and a fault flag during the DONE cycle.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam bit SINGLE = (LATENCY == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             is_store;
  logic [1:0]       lane;
  logic             acc_fault;
  logic             go_done;
  logic [3:0]       ram_we;
  logic             ram_re;
  logic [31:0]      ram_rdata;
  logic             fault_q;
  logic             ld_q;
  logic [2:0]       f3_q;
  logic [1:0]       lane_q;

  assign req       = mem_read | mem_write;
  assign is_store  = mem_write;
  assign lane      = addr[1:0];
  assign acc_fault = access_fault(is_store, funct3, lane);

  // Commit edge: the edge that enters DONE. Gated by rst_n so a store racing
  // reset is dropped rather than half-applied.
  assign go_done = rst_n && ((state == IDLE && req && SINGLE) ||
                             (state == WAIT && cnt == CNT_W'(1)));
  assign ram_we  = (go_done && is_store && !acc_fault) ? byte_en(funct3, lane) : 4'b0000;
  assign ram_re  = go_done && !is_store && !acc_fault;

  assign stall = rst_n && ((state == IDLE && req) || state == WAIT);

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .addr  (addr[AW+1:2]),
    .we    (ram_we),
    .wdata (store_data(funct3, wdata)),
    .re    (ram_re),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (SINGLE) state <= DONE;
          else begin
            state <= WAIT;
            cnt   <= CNT_W'(LATENCY - 1);
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      if (go_done) begin
        fault_q <= acc_fault;
        ld_q    <= !is_store && !acc_fault;
      end else if (state == DONE) begin
        fault_q <= 1'b0;
      end
    end
  end

  // Size/lane of the captured load, needed to extend the RAM output word.
  always_ff @(posedge clk) begin
    if (go_done) begin
      f3_q   <= funct3;
      lane_q <= lane;
    end
  end

  assign rdata = ld_q ? load_extend(f3_q, lane_q, ram_rdata) : 32'h0;
  assign fault = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboarded bench for data_mem_ctrl: directed loads/stores, faults, wrap,
// priority, reset during WAIT and a LATENCY=1 instance.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rdata;
  logic        stall, fault;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [2:0]  f3_1 = '0;
  logic [31:0] rdata1;
  logic        stall1, fault1;

  typedef struct {
    bit          chk_rdata;
    logic [31:0] rdata;
    logic        fault;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .funct3(funct3),
    .rdata(rdata), .stall(stall), .fault(fault)
  );

  data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
    .addr(addr1), .wdata(wdata1), .funct3(f3_1),
    .rdata(rdata1), .stall(stall1), .fault(fault1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  // Monitor: a DONE cycle is the first non-stalled cycle after a stalled one.
  initial begin
    bit prev_stall;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall && !stall) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_fault"}, {31'h0, fault}, {31'h0, e.fault});
          if (e.chk_rdata) check({e.name, "_rdata"}, rdata, e.rdata);
        end
      end
      prev_stall = rst_n ? stall : 1'b0;
    end
  end

  // Issue one access on dut (called #1 after a rising edge, FSM in IDLE).
  task automatic acc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input bit chk, input logic [31:0] exp_rd,
                     input logic exp_f, input string nm);
    int  n;
    bit  done;
    sb.push_back('{chk, exp_rd, exp_f, nm});
    mem_read = rd; mem_write = wr; addr = a; wdata = d; funct3 = f3;
    n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    check({nm, "_stall_cycles"}, n, 2);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic acc1(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input bit chk, input logic [31:0] exp_rd,
                      input string nm);
    int n;
    bit done;
    rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; f3_1 = f3;
    n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall1) n++;
      else done = 1'b1;
    end
    check({nm, "_stall_cycles"}, n, 1);
    check({nm, "_fault"}, {31'h0, fault1}, 32'h0);
    if (chk) check({nm, "_rdata"}, rdata1, exp_rd);
    @(posedge clk); #1;
    rd1 = 1'b0; wr1 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_stall", {31'h0, stall}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_fault", {31'h0, fault}, 32'h0);
    @(posedge clk); #1;

    // Basic word store/load
    acc(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 0, "sw_10");
    acc(1, 0, 32'h10, 32'h0, 3'b010, 1, 32'hDEADBEEF, 0, "lw_10");

    // Extension
    acc(0, 1, 32'h20, 32'h80FF7F01, 3'b010, 0, 32'h0, 0, "sw_20");
    acc(1, 0, 32'h23, 32'h0, 3'b000, 1, 32'hFFFFFF80, 0, "lb_23");
    acc(1, 0, 32'h23, 32'h0, 3'b100, 1, 32'h00000080, 0, "lbu_23");
    acc(1, 0, 32'h22, 32'h0, 3'b001, 1, 32'hFFFF80FF, 0, "lh_22");
    acc(1, 0, 32'h20, 32'h0, 3'b101, 1, 32'h00007F01, 0, "lhu_20");
    acc(1, 0, 32'h21, 32'h0, 3'b000, 1, 32'h0000007F, 0, "lb_21");

    // Partial store
    acc(0, 1, 32'h30, 32'h11223344, 3'b010, 0, 32'h0, 0, "sw_30");
    acc(0, 1, 32'h31, 32'h000000AA, 3'b000, 0, 32'h0, 0, "sb_31");
    acc(1, 0, 32'h30, 32'h0, 3'b010, 1, 32'h1122AA44, 0, "lw_30");
    acc(0, 1, 32'h32, 32'h0000BEEF, 3'b001, 0, 32'h0, 0, "sh_32");
    acc(1, 0, 32'h30, 32'h0, 3'b010, 1, 32'hBEEFAA44, 0, "lw_30b");

    // Faults
    acc(1, 0, 32'h06, 32'h0, 3'b010, 1, 32'h0, 1, "lw_06_misalign");
    @(negedge clk);
    check("fault_clears", {31'h0, fault}, 32'h0);
    @(posedge clk); #1;
    acc(0, 1, 32'h40, 32'h99887766, 3'b010, 0, 32'h0, 0, "sw_40");
    acc(0, 1, 32'h41, 32'h0000FFFF, 3'b001, 0, 32'h0, 1, "sh_41_misalign");
    acc(1, 0, 32'h40, 32'h0, 3'b010, 1, 32'h99887766, 0, "lw_40_after_sh");
    acc(1, 0, 32'h44, 32'h0, 3'b011, 1, 32'h0, 1, "load_f3_011");
    acc(0, 1, 32'h40, 32'h0, 3'b100, 0, 32'h0, 1, "store_f3_100");
    acc(1, 0, 32'h40, 32'h0, 3'b010, 1, 32'h99887766, 0, "lw_40_after_bad");
    acc(1, 0, 32'h43, 32'h0, 3'b101, 1, 32'h0, 1, "lhu_43_misalign");

    // Wrap and priority
    acc(0, 1, 32'h1000, 32'hCAFEF00D, 3'b010, 0, 32'h0, 0, "sw_1000");
    acc(1, 0, 32'h0, 32'h0, 3'b010, 1, 32'hCAFEF00D, 0, "lw_0_wrap");
    acc(1, 1, 32'h50, 32'h0BADC0DE, 3'b010, 0, 32'h0, 0, "rw_both");
    acc(1, 0, 32'h50, 32'h0, 3'b010, 1, 32'h0BADC0DE, 0, "lw_50");

    // Reset during WAIT drops the store
    acc(0, 1, 32'h08, 32'h12345678, 3'b010, 0, 32'h0, 0, "sw_08");
    mem_write = 1'b1; addr = 32'h08; wdata = 32'h00000055; funct3 = 3'b010;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_stall", {31'h0, stall}, 32'h0);
    mem_write = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    acc(1, 0, 32'h08, 32'h0, 3'b010, 1, 32'h12345678, 0, "lw_08_after_rst");

    // LATENCY=1 instance
    acc1(0, 1, 32'h60, 32'hA5A5_0F0F, 3'b010, 0, 32'h0, "l1_sw_60");
    acc1(1, 0, 32'h60, 32'h0, 3'b010, 1, 32'hA5A50F0F, "l1_lw_60");
    acc1(1, 0, 32'h62, 32'h0, 3'b001, 1, 32'hFFFFA5A5, "l1_lh_62");

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
